// File: rtl/pc_sequencer.sv
// Program-counter sequencer: a chain of 4-bit counter slices with two-phase jump loading.
// Optional macro PC_HITMP_AUTOCLR_EN: a taken jump also clears the staged high part.
module pc_sequencer #(
    parameter int                   NIBBLES    = 4,
    parameter logic [4*NIBBLES-1:0] RESET_ADDR = '0
) (
    input  logic                   CP,
    input  logic                   _MR,
    input  logic                   INC,
    input  logic                   _PCHITMP_IN,
    input  logic                   _PCLO_IN,
    input  logic                   _JMP_COND,
    input  logic                   COND,
    input  logic [7:0]             D,
    output logic [4*NIBBLES-1:0]   PC,
    output logic [4*NIBBLES-9:0]   PCHITMP,
    output logic                   TC,
    output logic                   JUMPED,
    output logic                   FAULT
);

    localparam int W    = 4 * NIBBLES;
    localparam int HI_W = W - 8;

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t          state;
    logic [W-1:0]    pc_inc;
    logic [HI_W-1:0] d_hi;
    logic            take;
    logic            ripple;

    assign d_hi = HI_W'(D);
    assign take = ~_PCLO_IN | (~_JMP_COND & COND);

    // Each slice counts only while every lower slice is at 1111, like TC->CET on a 74163 chain.
    always_comb begin
        ripple = INC;
        pc_inc = PC;
        for (int i = 0; i < NIBBLES; i++) begin
            pc_inc[4*i +: 4] = PC[4*i +: 4] + {3'b000, ripple};
            ripple           = ripple & (PC[4*i +: 4] == 4'hF);
        end
    end

    assign TC = ripple;

    always_ff @(posedge CP or negedge _MR) begin
        if (!_MR) begin
            PC      <= RESET_ADDR;
            PCHITMP <= '0;
            JUMPED  <= 1'b0;
            FAULT   <= 1'b0;
            state   <= IDLE;
        end else begin
            if (!_PCHITMP_IN) begin
                PCHITMP <= d_hi;
                state   <= ARMED;
            end
`ifdef PC_HITMP_AUTOCLR_EN
            else if (take) begin
                PCHITMP <= '0;
                state   <= IDLE;
            end
`endif
            // The jump always uses the high part as it stood before this edge.
            if (take) begin
                PC     <= {PCHITMP, D};
                JUMPED <= 1'b1;
                if (state == IDLE) begin
                    FAULT <= 1'b1;
                end
            end else begin
                JUMPED <= 1'b0;
                if (INC) begin
                    PC <= pc_inc;
                end
            end
        end
    end

endmodule
